// File: rtl/kernel_window.sv
// Sliding KxK window assembler at the tail of the line buffer chain.
// Accepts one pixel column per transfer and emits windows that lie wholly inside one image row band.
module kernel_window #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_WIDTH = 3,
  parameter int IMG_WIDTH    = 854,
  parameter int IMG_HEIGHT   = 480,
  parameter int XW           = $clog2(IMG_WIDTH),
  parameter int YW           = $clog2(IMG_HEIGHT)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [KERNEL_WIDTH*DATA_WIDTH-1:0]         col_data,
  input  logic                                       col_valid,
  output logic                                       col_ready,
  output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0] win_data,
  output logic                                       win_valid,
  input  logic                                       win_ready,
  output logic [XW-1:0]                              win_x,
  output logic [YW-1:0]                              win_y,
  output logic                                       win_last
);

  localparam int K  = KERNEL_WIDTH;
  localparam int CW = K * DATA_WIDTH;
  localparam int WW = K * K * DATA_WIDTH;

  localparam logic [XW-1:0] XLast  = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0] XFirst = XW'(K - 1);
  localparam logic [YW-1:0] YLast  = YW'(IMG_HEIGHT - K);

  logic [CW-1:0] cols_q [K];
  logic [CW-1:0] cols_d [K];
  logic [CW-1:0] shifted [K];
  logic [WW-1:0] win_pack;

  logic [XW-1:0] col_x_q, col_x_d;
  logic [YW-1:0] row_y_q, row_y_d;

  logic          win_valid_q, win_valid_d;
  logic [WW-1:0] win_data_q, win_data_d;
  logic [XW-1:0] win_x_q, win_x_d;
  logic [YW-1:0] win_y_q, win_y_d;
  logic          win_last_q, win_last_d;

  logic accept;
  logic xfer;

  assign col_ready = ~win_valid_q | win_ready;
  assign accept    = col_valid & col_ready;
  assign xfer      = win_valid_q & win_ready;

  always_comb begin
    for (int c = 0; c < K - 1; c++) begin
      shifted[c] = cols_q[c + 1];
    end
    shifted[K - 1] = col_data;

    win_pack = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_pack[(r*K + c)*DATA_WIDTH +: DATA_WIDTH] = shifted[c][r*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    for (int c = 0; c < K; c++) begin
      cols_d[c] = cols_q[c];
    end
    col_x_d     = col_x_q;
    row_y_d     = row_y_q;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    win_last_d  = win_last_q;

    if (accept) begin
      for (int c = 0; c < K; c++) begin
        cols_d[c] = shifted[c];
      end

      if (col_x_q == XLast) begin
        col_x_d = '0;
        row_y_d = (row_y_q == YLast) ? '0 : row_y_q + YW'(1);
      end else begin
        col_x_d = col_x_q + XW'(1);
      end

      // The first K-1 columns of each row would mix in stale pixels from the row above.
      if (col_x_q >= XFirst) begin
        win_valid_d = 1'b1;
        win_data_d  = win_pack;
        win_x_d     = col_x_q - XFirst;
        win_y_d     = row_y_q;
        win_last_d  = (row_y_q == YLast) && (col_x_q == XLast);
      end else if (xfer) begin
        win_valid_d = 1'b0;
      end
    end else if (xfer) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < K; c++) begin
        cols_q[c] <= '0;
      end
      col_x_q     <= '0;
      row_y_q     <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_last_q  <= 1'b0;
    end else begin
      for (int c = 0; c < K; c++) begin
        cols_q[c] <= cols_d[c];
      end
      col_x_q     <= col_x_d;
      row_y_q     <= row_y_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign win_last  = win_last_q;

endmodule

// File: tb/tb_kernel_window.sv
// Directed bench for kernel_window on a 6x5 image with a 3x3 kernel.
// Pixel value is row*16+col, so every expected window follows from its coordinates.
module tb_kernel_window;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] col_data;
  logic        col_valid;
  logic        col_ready;
  logic [71:0] win_data;
  logic        win_valid;
  logic        win_ready;
  logic [2:0]  win_x;
  logic [2:0]  win_y;
  logic        win_last;

  kernel_window #(
    .DATA_WIDTH(8), .KERNEL_WIDTH(3), .IMG_WIDTH(6), .IMG_HEIGHT(5)
  ) dut (
    .clk(clk), .rst(rst),
    .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .win_x(win_x), .win_y(win_y), .win_last(win_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: stream position and the expected output register.
  int          mX = 0, mY = 0, mAccepts = 0, mXfer = 0;
  logic        mValid = 1'b0, mLast = 1'b0;
  logic [2:0]  mWx = '0, mWy = '0;
  logic [71:0] mData = '0;

  int          nXfer = 0, nLast = 0;
  logic [2:0]  lastX = '0, lastY = '0;
  logic        sReady, eReady;

  logic [79:0] dutBundle;
  assign dutBundle = {win_valid, win_x, win_y, win_last, win_data};

  function automatic logic [79:0] expBundle();
    return {mValid, mWx, mWy, mLast, mData};
  endfunction

  function automatic logic [23:0] colFor(input int x, input int y);
    logic [23:0] v;
    for (int r = 0; r < 3; r++) v[r*8 +: 8] = 8'((y + r) * 16 + x);
    return v;
  endfunction

  function automatic logic [71:0] winFor(input int x, input int y);
    logic [71:0] v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3 + c)*8 +: 8] = 8'((y + r) * 16 + x + c);
    return v;
  endfunction

  // One clock of stimulus, entered and left on a falling edge; updates the model only.
  task automatic drive(input logic cv, input logic wr, input logic rs);
    logic acc;
    col_valid = cv;
    win_ready = wr;
    rst       = rs;
    col_data  = cv ? colFor(mX, mY) : 24'hEEEEEE;
    #1;
    sReady = col_ready;
    eReady = !mValid || wr;
    if (!rs && win_valid && win_ready) begin
      nXfer++;
      if (win_last) begin
        nLast++;
        lastX = win_x;
        lastY = win_y;
      end
    end
    if (!rs && mValid && wr) mXfer++;
    acc = !rs && cv && eReady;
    @(posedge clk);
    if (rs) begin
      mX = 0; mY = 0; mValid = 1'b0; mLast = 1'b0;
      mWx = '0; mWy = '0; mData = '0;
    end else begin
      if (acc && mX >= 2) begin
        mValid = 1'b1;
        mWx    = 3'(mX - 2);
        mWy    = 3'(mY);
        mLast  = (mY == 2) && (mX == 5);
        mData  = winFor(mX - 2, mY);
      end else if (mValid && wr) begin
        mValid = 1'b0;
      end
      if (acc) begin
        mAccepts++;
        if (mX == 5) begin
          mX = 0;
          mY = (mY == 2) ? 0 : mY + 1;
        end else begin
          mX++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      checks++;
      if (dutBundle !== 80'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs got=%h exp=0", dutBundle);
      end
      checks++;
      if (col_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_ready got=%b exp=1", col_ready);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      checks++;
      if (win_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle_valid got=%b exp=0", win_valid);
      end
    end
  endtask

  task automatic test_single_row();
    int base;
    base = nXfer;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (sReady !== eReady) begin
        errors++;
        $display("[TB] FAIL row_ready col=%0d got=%b exp=%b", i, sReady, eReady);
      end
      checks++;
      if (dutBundle !== expBundle()) begin
        errors++;
        $display("[TB] FAIL row_window col=%0d got=%h exp=%h", i, dutBundle, expBundle());
      end
      if (i < 2) begin
        checks++;
        if (win_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL row_border col=%0d got=%b exp=0", i, win_valid);
        end
      end
      if (i == 2) begin
        checks++;
        if ({win_valid, win_x, win_data[23:0]} !== {1'b1, 3'd0, 24'h020100}) begin
          errors++;
          $display("[TB] FAIL row_first got=%b/%0d/%h exp=1/0/020100", win_valid, win_x, win_data[23:0]);
        end
      end
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (nXfer - base !== 4) begin
      errors++;
      $display("[TB] FAIL row_count got=%0d exp=4", nXfer - base);
    end
  endtask

  task automatic test_full_frame();
    int base, baseLast;
    drive(1'b0, 1'b1, 1'b1);
    base = nXfer;
    baseLast = nLast;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (dutBundle !== expBundle()) begin
        errors++;
        $display("[TB] FAIL frame_window col=%0d got=%h exp=%h", i, dutBundle, expBundle());
      end
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (nXfer - base !== 12) begin
      errors++;
      $display("[TB] FAIL frame_count got=%0d exp=12", nXfer - base);
    end
    checks++;
    if ({nLast - baseLast, lastX, lastY} !== {32'd1, 3'd3, 3'd2}) begin
      errors++;
      $display("[TB] FAIL frame_last got=%0d@(%0d,%0d) exp=1@(3,2)", nLast - baseLast, lastX, lastY);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (win_valid !== (i == 2)) begin
        errors++;
        $display("[TB] FAIL frame_wrap col=%0d got=%b exp=%b", i, win_valid, (i == 2));
      end
    end
    checks++;
    if ({win_x, win_y, win_data[23:0]} !== {3'd0, 3'd0, 24'h020100}) begin
      errors++;
      $display("[TB] FAIL frame_wrap_pos got=%0d,%0d,%h exp=0,0,020100", win_x, win_y, win_data[23:0]);
    end
  endtask

  task automatic test_back_pressure();
    int base;
    base = nXfer - mXfer;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (sReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_ready cyc=%0d got=%b exp=0", i, sReady);
      end
      checks++;
      if (dutBundle !== expBundle()) begin
        errors++;
        $display("[TB] FAIL bp_hold cyc=%0d got=%h exp=%h", i, dutBundle, expBundle());
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (dutBundle !== expBundle()) begin
        errors++;
        $display("[TB] FAIL bp_resume cyc=%0d got=%h exp=%h", i, dutBundle, expBundle());
      end
    end
    checks++;
    if (nXfer - mXfer !== base) begin
      errors++;
      $display("[TB] FAIL bp_xfer_count got=%0d exp=%0d", nXfer - mXfer, base);
    end
  endtask

  task automatic test_random_stalls();
    int target, cyc, bad, base;
    drive(1'b0, 1'b1, 1'b1);
    base = nXfer - mXfer;
    target = mAccepts + 54;
    cyc = 0;
    bad = 0;
    while (mAccepts < target && cyc < 2000) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0);
      cyc++;
      if (sReady !== eReady || dutBundle !== expBundle()) begin
        bad++;
        if (bad <= 5)
          $display("[TB] FAIL rand_cycle cyc=%0d got=%b/%h exp=%b/%h", cyc, sReady, dutBundle, eReady, expBundle());
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (mAccepts < target) begin
      errors++;
      $display("[TB] FAIL rand_timeout got=%0d exp=%0d accepts", mAccepts, target);
    end
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (nXfer - mXfer !== base) begin
      errors++;
      $display("[TB] FAIL rand_xfer_count got=%0d exp=%0d", nXfer - mXfer, base);
    end
  endtask

  task automatic test_reset_mid_row();
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (win_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pending got=%b exp=1", win_valid);
    end
    drive(1'b1, 1'b0, 1'b1);
    checks++;
    if (win_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_valid got=%b exp=0", win_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (win_valid !== (i == 2)) begin
        errors++;
        $display("[TB] FAIL mid_restart col=%0d got=%b exp=%b", i, win_valid, (i == 2));
      end
    end
    checks++;
    if ({win_x, win_y, win_data} !== {3'd0, 3'd0, winFor(0, 0)}) begin
      errors++;
      $display("[TB] FAIL mid_window got=%0d,%0d,%h exp=0,0,%h", win_x, win_y, win_data, winFor(0, 0));
    end
  endtask

  initial begin
    rst       = 1'b1;
    col_valid = 1'b0;
    win_ready = 1'b1;
    col_data  = '0;
    @(negedge clk);
    test_reset();
    test_single_row();
    test_full_frame();
    test_back_pressure();
    test_random_stalls();
    test_reset_mid_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
